mem_port_arbiter: RTL

- Shares one OBI-style memory port between the fetch stage (read-only instruction requester) and the load/store unit (read/write data requester).
- Arbitrates address phases and tracks in-flight transactions in an ordered owner queue.
- Routes each rvalid response back to the requester that issued it.
- Discards stale instruction responses after a fetch flush (branch/trap redirect). Sits between the fetch/LSU stages and the single-ported memory/bus adapter.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_port_arbiter_fifo.sv | 69 ++++++
 rtl/mem_port_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/LSU memory port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e owner;
    logic   discard;
  } arb_entry_t;

  typedef enum logic [1:0] {
    LK_NONE  = 2'd0,
    LK_INSTR = 2'd1,
    LK_DATA  = 2'd2
  } lock_e;

  localparam logic [3:0] INSTR_BE = 4'hF;

  function automatic lock_e lock_of(input owner_e o);
    return (o == OWN_DATA) ? LK_DATA : LK_INSTR;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_fifo.sv
// Ordered owner queue of in-flight transactions;
// flush_mark tags every queued instr entry for discard.
import mem_arb_pkg::*;

module arb_owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  owner_e     push_owner,
  input  logic       pop,
  input  logic       flush_mark,
  output arb_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  arb_entry_t          entries [DEPTH];
  logic       [PW-1:0] rd_ptr;
  logic       [PW-1:0] wr_ptr;
  logic       [CW-1:0] count;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head  = entries[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (flush_mark) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (entries[i].owner == OWN_INSTR) begin
            entries[i].discard <= 1'b1;
          end
        end
      end
      // push after marking: the new entry belongs to the redirected PC
      if (push) begin
        entries[wr_ptr] <= '{owner: push_owner, discard: 1'b0};
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/LSU arbiter for one OBI memory port with response routing.
// MEM_ARB_RR_EN selects round-robin instead of data priority.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4,
  parameter int CNT_W           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        instr_flush_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        proto_err_o
);

  lock_e      state;
  lock_e      state_nxt;
  owner_e     winner;
  owner_e     free_win;
  logic       lock_hold;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  arb_entry_t head;

  assign mem_req_o = (instr_req_i | data_req_i) & ~full;
  assign push      = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & ~empty;

  // a lock whose owner dropped req is released
  assign lock_hold = (state == LK_DATA  & data_req_i)
                   | (state == LK_INSTR & instr_req_i);

`ifdef MEM_ARB_RR_EN
  owner_e last_own;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_own <= OWN_INSTR;
    end else if (push) begin
      last_own <= winner;
    end
  end

  always_comb begin
    free_win = OWN_INSTR;
    if (instr_req_i & data_req_i) begin
      free_win = (last_own == OWN_DATA) ? OWN_INSTR : OWN_DATA;
    end else if (data_req_i) begin
      free_win = OWN_DATA;
    end
  end
`else
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = instr_req_i
                 & (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    free_win = OWN_INSTR;
    if (data_req_i & ~starved) begin
      free_win = OWN_DATA;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (!instr_req_i | instr_gnt_o | instr_flush_i) begin
      starve_cnt <= '0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= LK_NONE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = LK_NONE;
    if (mem_req_o & ~mem_gnt_i) begin
      state_nxt = lock_of(winner);
    end
  end

  always_comb begin
    winner      = free_win;
    mem_we_o    = 1'b0;
    mem_be_o    = INSTR_BE;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (lock_hold) begin
      winner = (state == LK_DATA) ? OWN_DATA : OWN_INSTR;
    end
    unique case (1'b1)
      mem_req_o & (winner == OWN_DATA): begin
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end
      mem_req_o & (winner == OWN_INSTR): begin
        mem_addr_o  = instr_addr_i;
      end
      default: ;
    endcase
    instr_gnt_o = push & (winner == OWN_INSTR);
    data_gnt_o  = push & (winner == OWN_DATA);
  end

  arb_owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_owner(winner),
    .pop       (pop),
    .flush_mark(instr_flush_i),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign instr_rvalid_o = pop & (head.owner == OWN_INSTR)
                        & ~head.discard & ~instr_flush_i;
  assign data_rvalid_o  = pop & (head.owner == OWN_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      proto_err_o <= 1'b0;
    end else if (mem_rvalid_i & empty) begin
      proto_err_o <= 1'b1;
    end
  end

endmodule
